sdrd_capture: RTL and testbench
===============================

SDRD_CAPTURE -- requirements
Module: sdrd_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which is the FIFO depth in bytes and must be a power of two, 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port acc_stb, input, 1 bit: one-clk pulse marking the end of one bus access.
REQ-005 SHALL have port SSER, input, 1 bit: serial window select, active low.
REQ-006 SHALL have ports BA13 and BA12, input, 1 bit each: buffered address decode bits.
REQ-007 SHALL have port BR_W, input, 1 bit: buffered read/write; 1 = read.
REQ-008 SHALL have port SDRD, input, 1 bit: serial read data driven by the upstream sequencer during qualified reads.
REQ-009 SHALL have port rd_en, input, 1 bit: pop request.
REQ-010 SHALL have port rd_data, output, 8 bits: FIFO head byte.
REQ-011 SHALL have port rd_valid, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-013 SHALL have port ovf_clr, input, 1 bit: clears ovf.
REQ-014 SHALL have port perr, output, 1 bit: sticky parity error; present only under the parity build (see Configuration).

Function
REQ-015 SHALL define a window access as acc_stb & ~SSER & ~BA13 & BA12; a qualified read is a window access with BR_W=1, and a restart is a window access with BR_W=0.
REQ-016 SHALL sample SDRD on each qualified read into an 8-bit shift register, MSB first.
REQ-017 SHALL implement states IDLE (0 bits held), SHIFT (1..7 bits held) and, under the parity build only, PAR (8 bits held, awaiting parity bit).
REQ-018 SHALL follow these transitions:
- IDLE->SHIFT on a qualified read.
- SHIFT->SHIFT while fewer than 8 bits are held.
- On the 8th bit: push the byte and go to IDLE, or go to PAR under the parity build.
- PAR->IDLE on the next qualified read, then push the byte.
REQ-019 SHALL, on a restart in any state, discard the partial byte, return to IDLE, and leave the FIFO unchanged.
REQ-020 SHALL assert rd_valid, with the new byte at rd_data, in the clk cycle after the acc_stb that completes the byte when the FIFO was empty.
REQ-021 SHALL present the head byte on rd_data whenever rd_valid=1; rd_data is don't-care when empty.
REQ-022 SHALL remove the head byte on rd_en=1 with rd_valid=1; rd_en while empty is ignored.
REQ-023 SHALL, on a push while the FIFO is full and rd_en=0, drop the byte, set ovf, and leave the FIFO contents intact.
REQ-024 SHALL, on a simultaneous push and pop while full, perform both; ovf is not set.
REQ-025 SHALL, on a simultaneous push and pop while empty, leave rd_valid=1 holding the new byte.
REQ-026 SHALL wrap the FIFO pointers modulo DEPTH; occupancy counts 0..DEPTH.
REQ-027 SHALL clear ovf one cycle after ovf_clr=1; if ovf_clr and a new overflow coincide, ovf remains 1.
REQ-028 SHALL ignore SDRD, rd_data changes and all bus inputs outside qualified accesses.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, force state IDLE, bit count 0, shift register 0, FIFO empty (rd_valid=0), ovf=0 and perr=0.
REQ-030 SHALL give rst priority over all simultaneous events; a partial byte in progress is lost.

Configuration
REQ-031 SHALL provide macro SDRD_CAPTURE_PARITY_EN.
REQ-032 SHALL, when SDRD_CAPTURE_PARITY_EN is defined:
- Take a 9th qualified-read bit as odd parity over the 8 data bits.
- On mismatch, drop the byte and set perr (sticky, cleared by ovf_clr or rst).
- On a good byte, push it.
REQ-033 SHALL, when SDRD_CAPTURE_PARITY_EN is undefined, omit the PAR state and the perr port, and push on the 8th bit.

Verification
REQ-034 Eight qualified reads with SDRD=1,0,1,0,0,1,0,1 (no parity build) SHALL give rd_valid=1 and rd_data=8'hA5 one cycle after the 8th acc_stb.
REQ-035 Three qualified reads followed by a restart, then eight reads of 8'h3C SHALL give exactly one byte of 8'h3C.
REQ-036 Five bytes 01..05 with DEPTH=4 and no pops SHALL give ovf=1, then pops return 01,02,03,04 and rd_valid=0.
REQ-037 A full FIFO with the 5th byte completing while rd_en=1 SHALL keep ovf=0, pop 01, and leave 02..05 queued.
REQ-038 Accesses with SSER=1, BA13=1 or BA12=0 SHALL cause no shift or state change.
REQ-039 Under the parity build, 8'hA5 with parity bit 1 SHALL be pushed; 8'hA5 with parity bit 0 SHALL be dropped with perr=1; rst mid-byte SHALL clear both.

Source files
------------

// File: rtl/sdrd_capture.sv
// sdrd_capture: deserialises SDRD bits sampled on qualified serial-window
// reads into bytes (MSB first) and queues them in a small FIFO.
// Optional build macro SDRD_CAPTURE_PARITY_EN adds a 9th odd-parity bit per
// byte, a PAR state and a sticky perr output.
module sdrd_capture #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       acc_stb,
   input  logic       SSER,
   input  logic       BA13,
   input  logic       BA12,
   input  logic       BR_W,
   input  logic       SDRD,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       ovf_clr,
   output logic       ovf
`ifdef SDRD_CAPTURE_PARITY_EN
   ,
   output logic       perr
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

`ifdef SDRD_CAPTURE_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t       state_q, state_d;
   logic [2:0]   bcnt_q, bcnt_d;
   logic [7:0]   shreg_q, shreg_d;
   logic         push;
   logic [7:0]   push_byte;

   logic [7:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic         ovf_q;
   logic         full, pop, push_ok, ovf_set;

   // Bus decode: only the serial window at BA13:BA12 = 01 counts.
   logic window, qrd, restart;
   assign window  = acc_stb & ~SSER & ~BA13 & BA12;
   assign qrd     = window & BR_W;
   assign restart = window & ~BR_W;

`ifdef SDRD_CAPTURE_PARITY_EN
   logic perr_set;
   logic perr_q;
   assign perr = perr_q;
`endif

   // Deserialiser state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bcnt_q  <= 3'd0;
         shreg_q <= 8'd0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
      end
   end

   // Next-state: shift on qualified reads, abandon the byte on a restart.
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      push_byte = shreg_q;
`ifdef SDRD_CAPTURE_PARITY_EN
      perr_set  = 1'b0;
`endif
      if (restart) begin
         state_d = IDLE;
         bcnt_d  = 3'd0;
         shreg_d = 8'd0;
      end else if (qrd) begin
         case (state_q)
            IDLE, SHIFT: begin
               shreg_d = {shreg_q[6:0], SDRD};
               if (bcnt_q == 3'd7) begin
`ifdef SDRD_CAPTURE_PARITY_EN
                  // Full byte held; wait for the parity bit before queuing.
                  state_d = PAR;
                  bcnt_d  = 3'd0;
`else
                  push      = 1'b1;
                  push_byte = {shreg_q[6:0], SDRD};
                  state_d   = IDLE;
                  bcnt_d    = 3'd0;
                  shreg_d   = 8'd0;
`endif
               end else begin
                  state_d = SHIFT;
                  bcnt_d  = bcnt_q + 3'd1;
               end
            end
`ifdef SDRD_CAPTURE_PARITY_EN
            PAR: begin
               // Odd parity: data plus parity bit must hold an odd number of ones.
               push_byte = shreg_q;
               if (^{shreg_q, SDRD}) begin
                  push = 1'b1;
               end else begin
                  perr_set = 1'b1;
               end
               state_d = IDLE;
               bcnt_d  = 3'd0;
               shreg_d = 8'd0;
            end
`endif
            default: begin
               state_d = IDLE;
               bcnt_d  = 3'd0;
               shreg_d = 8'd0;
            end
         endcase
      end
   end

   assign full    = (cnt_q == CW'(DEPTH));
   assign pop     = rd_en & (cnt_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   // FIFO pointers, occupancy and sticky flags; new events beat clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop)     rd_q <= rd_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

`ifdef SDRD_CAPTURE_PARITY_EN
   // Sticky parity error, cleared by the same clear strobe as overflow.
   always_ff @(posedge clk) begin
      if (rst)           perr_q <= 1'b0;
      else if (perr_set) perr_q <= 1'b1;
      else if (ovf_clr)  perr_q <= 1'b0;
   end
`endif

   // FIFO storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= push_byte;
   end

   // Head byte is read combinationally so it is valid alongside rd_valid.
   assign rd_data  = mem_q[rd_q];
   assign rd_valid = (cnt_q != '0);
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_sdrd_capture.sv
// Directed bench for sdrd_capture with an expected-byte scoreboard; a
// negedge monitor checks every popped byte against the queue.
module tb_sdrd_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       acc_stb = 1'b0;
   logic       SSER = 1'b1;
   logic       BA13 = 1'b0;
   logic       BA12 = 1'b0;
   logic       BR_W = 1'b0;
   logic       SDRD = 1'b0;
   logic       rd_en = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       ovf;
`ifdef SDRD_CAPTURE_PARITY_EN
   logic       perr;
`endif

   int passed = 0;
   int total  = 0;
   logic [7:0] exp_q [$];

   sdrd_capture #(.DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .acc_stb  (acc_stb),
      .SSER     (SSER),
      .BA13     (BA13),
      .BA12     (BA12),
      .BR_W     (BR_W),
      .SDRD     (SDRD),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .ovf_clr  (ovf_clr),
      .ovf      (ovf)
`ifdef SDRD_CAPTURE_PARITY_EN
      ,
      .perr     (perr)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) begin
         passed++;
         $display("check %-14s act=%02h exp=%02h ok", name, act, exp);
      end else begin
         $display("FAIL %s actual=%02h required=%02h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next posedge whenever rd_en and rd_valid.
   always @(negedge clk) begin
      if (!rst && rd_en) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               check("pop_unexpected", rd_data, 8'hxx);
            end else begin
               check("pop_data", rd_data, exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            check("pop_missing", 8'h00, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   // One bus access lasting one clock; inputs change 1 time unit after posedge.
   task automatic acc(input logic sser, input logic ba13, input logic ba12,
                      input logic brw, input logic d, input logic ren, input logic clr);
      acc_stb = 1'b1; SSER = sser; BA13 = ba13; BA12 = ba12; BR_W = brw; SDRD = d;
      rd_en = ren; ovf_clr = clr;
      @(posedge clk); #1;
      acc_stb = 1'b0; SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b0; BR_W = 1'b0; SDRD = ~d;
      rd_en = 1'b0; ovf_clr = 1'b0;
   endtask

   task automatic rd(input logic d);
      acc(1'b0, 1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic send_partial(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) rd(b[7-i]);
   endtask

   // Final access of a byte (bit 0, plus odd parity in the parity build).
   task automatic send_tail(input logic [7:0] b, input logic ren, input logic clr);
`ifdef SDRD_CAPTURE_PARITY_EN
      rd(b[0]);
      acc(1'b0, 1'b0, 1'b1, 1'b1, ~^b, ren, clr);
`else
      acc(1'b0, 1'b0, 1'b1, 1'b1, b[0], ren, clr);
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input logic ren, input logic clr);
      send_partial(b, 7);
      send_tail(b, ren, clr);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      do_reset();
      check("rst_valid", {7'd0, rd_valid}, 8'h00);
      check("rst_ovf", {7'd0, ovf}, 8'h00);

      // A5 MSB first: valid exactly one cycle after the final strobe.
      send_partial(8'hA5, 7);
      check("a5_not_yet", {7'd0, rd_valid}, 8'h00);
      send_tail(8'hA5, 1'b0, 1'b0);
      check("a5_valid", {7'd0, rd_valid}, 8'h01);
      check("a5_head", rd_data, 8'hA5);
      exp_q.push_back(8'hA5);
      pop_one();

      // Three bits then restart: partial byte discarded.
      rd(1'b1); rd(1'b1); rd(1'b1);
      acc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("restart_empty", {7'd0, rd_valid}, 8'h00);
      send_byte(8'h3C, 1'b0, 1'b0);
      check("3c_head", rd_data, 8'h3C);
      exp_q.push_back(8'h3C);
      pop_one();
      check("3c_only_one", {7'd0, rd_valid}, 8'h00);

      // Off-window accesses interleaved with a real byte must not disturb it.
      b = 8'h96;
      for (int i = 7; i >= 1; i--) begin
         rd(b[i]);
         acc(1'b1, 1'b0, 1'b1, 1'b1, ~b[i], 1'b0, 1'b0);
         acc(1'b0, 1'b1, 1'b1, 1'b1, ~b[i], 1'b0, 1'b0);
         acc(1'b0, 1'b0, 1'b0, 1'b1, ~b[i], 1'b0, 1'b0);
         acc(1'b1, 1'b0, 1'b1, 1'b0, ~b[i], 1'b0, 1'b0);
      end
      check("offwin_no_byte", {7'd0, rd_valid}, 8'h00);
      send_tail(b, 1'b0, 1'b0);
      check("offwin_head", rd_data, 8'h96);
      exp_q.push_back(8'h96);
      pop_one();

      // Five bytes into a 4-deep FIFO: fifth dropped, overflow flagged.
      for (int i = 1; i <= 4; i++) begin
         b = 8'(i);
         send_byte(b, 1'b0, 1'b0);
         exp_q.push_back(b);
      end
      check("full_no_ovf", {7'd0, ovf}, 8'h00);
      send_byte(8'h05, 1'b0, 1'b0);
      check("ovf_set", {7'd0, ovf}, 8'h01);
      repeat (4) pop_one();
      check("drained", {7'd0, rd_valid}, 8'h00);
      pop_one();
      check("ovf_sticky", {7'd0, ovf}, 8'h01);
      pulse_clr();
      check("ovf_cleared", {7'd0, ovf}, 8'h00);

      // Fifth byte completes during a pop: both happen, no overflow.
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b0);
      send_byte(8'h05, 1'b1, 1'b0);
      check("pushpop_no_ovf", {7'd0, ovf}, 8'h00);
      repeat (4) pop_one();
      check("pushpop_drain", {7'd0, rd_valid}, 8'h00);

      // Overflow coinciding with a clear keeps ovf set.
      for (int i = 0; i < 4; i++) begin
         b = 8'h11 + 8'(i);
         send_byte(b, 1'b0, 1'b0);
         exp_q.push_back(b);
      end
      send_byte(8'h15, 1'b0, 1'b1);
      check("ovf_beats_clr", {7'd0, ovf}, 8'h01);
      repeat (4) pop_one();
      pulse_clr();
      check("ovf_clr2", {7'd0, ovf}, 8'h00);

      // Push and pop together while empty: new byte remains valid.
      send_byte(8'h7E, 1'b1, 1'b0);
      check("empty_pp_valid", {7'd0, rd_valid}, 8'h01);
      check("empty_pp_head", rd_data, 8'h7E);
      exp_q.push_back(8'h7E);
      pop_one();

      // Reset mid-byte with a queued byte: everything cleared.
      send_byte(8'h11, 1'b0, 1'b0);
      send_partial(8'hFF, 4);
      do_reset();
      check("rst_mid_valid", {7'd0, rd_valid}, 8'h00);
      send_byte(8'hC3, 1'b0, 1'b0);
      check("after_rst_head", rd_data, 8'hC3);
      exp_q.push_back(8'hC3);
      pop_one();
      check("after_rst_empty", {7'd0, rd_valid}, 8'h00);

`ifdef SDRD_CAPTURE_PARITY_EN
      // Good parity pushes, bad parity drops and flags perr.
      send_partial(8'hA5, 8);
      acc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("par_good_head", rd_data, 8'hA5);
      exp_q.push_back(8'hA5);
      pop_one();
      check("par_good_perr", {7'd0, perr}, 8'h00);
      send_partial(8'hA5, 8);
      acc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("par_bad_drop", {7'd0, rd_valid}, 8'h00);
      check("par_bad_perr", {7'd0, perr}, 8'h01);
      pulse_clr();
      check("perr_clr", {7'd0, perr}, 8'h00);
      send_partial(8'hA5, 8);
      acc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send_partial(8'h5A, 3);
      do_reset();
      check("perr_rst", {7'd0, perr}, 8'h00);
      send_byte(8'h3C, 1'b0, 1'b0);
      check("par_rst_head", rd_data, 8'h3C);
      exp_q.push_back(8'h3C);
      pop_one();
`endif

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", 8'(exp_q.size()), 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
